// File: rtl/pipe_ctrl_chain.sv
// pipe_ctrl_chain
//   Linear chain of STAGES register stages with valid/ready handshaking at
//   both ends. Bubbles collapse: a stage moves forward whenever the stage
//   ahead of it is empty or empties on the same edge. A global freeze holds
//   every stage. A flush kills the FLUSH_DEPTH youngest stages, much like
//   a branch-taken squash.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   in_valid   upstream offers in_data
//   in_data    upstream payload (DATA_W bits)
//   in_ready   stage 0 accepts this cycle (combinational)
//   freeze     global stall; all stages hold
//   flush      kills stages 0..FLUSH_DEPTH-1
//   out_valid  output stage holds a valid entry
//   out_data   payload of the output stage, shown even when out_valid is low
//   out_ready  downstream accepts
//   occupancy  number of valid stages (registered)
//   flush_cnt  saturating count of flushes that killed at least one entry
module pipe_ctrl_chain #(
  parameter int DATA_W      = 32,
  parameter int STAGES      = 5,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        in_ready,
  input  logic                        freeze,
  input  logic                        flush,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  input  logic                        out_ready,
  output logic [$clog2(STAGES+1)-1:0] occupancy,
  output logic [15:0]                 flush_cnt
);

  localparam int OCC_W = $clog2(STAGES + 1);

  logic [STAGES-1:0] r_v;
  logic [DATA_W-1:0] r_d [STAGES];
  logic [OCC_W-1:0]  r_occ;
  logic [15:0]       r_fcnt;
  logic              r_run;

  logic [STAGES-1:0] w_leave;
  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_v_nxt;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_kill_any;

  function automatic logic [OCC_W-1:0] popcount(input logic [STAGES-1:0] v);
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < STAGES; i++) begin
      cnt = cnt + OCC_W'(v[i]);
    end
    return cnt;
  endfunction

  // Per-stage "entry leaves this edge", resolved from the output back to stage 0.
  always_comb begin
    logic l_go;
    w_leave = '0;
    // When the flush reaches the output stage the entry is killed, not delivered.
    l_go = r_v[STAGES-1] & out_ready & ~freeze & ~(flush & (FLUSH_DEPTH == STAGES));
    w_leave[STAGES-1] = l_go;
    for (int i = STAGES - 2; i >= 0; i--) begin
      l_go = r_v[i] & ~freeze & (~r_v[i+1] | l_go);
      w_leave[i] = l_go;
    end
  end

  // r_run stays low until the first edge after reset release, gating acceptance.
  assign w_in_ready = r_run & ~freeze & ~flush & (~r_v[0] | w_leave[0]);
  assign w_accept   = in_valid & w_in_ready;
  assign w_kill_any = flush & (|r_v[FLUSH_DEPTH-1:0]);

  // Per-stage load enable and next valid vector, including the flush kill zone.
  always_comb begin
    w_load  = '0;
    w_v_nxt = r_v;
    w_load[0] = w_accept;
    for (int i = 1; i < STAGES; i++) begin
      // Nothing crosses into or inside the flushed zone; stage FLUSH_DEPTH
      // must not receive the entry being killed at FLUSH_DEPTH-1.
      if (flush && (i <= FLUSH_DEPTH)) begin
        w_load[i] = 1'b0;
      end else begin
        w_load[i] = w_leave[i-1];
      end
    end
    for (int i = 0; i < STAGES; i++) begin
      if (flush && (i < FLUSH_DEPTH)) begin
        w_v_nxt[i] = 1'b0;
      end else if (w_load[i]) begin
        w_v_nxt[i] = 1'b1;
      end else if (w_leave[i]) begin
        w_v_nxt[i] = 1'b0;
      end else begin
        w_v_nxt[i] = r_v[i];
      end
    end
  end

  // Stage registers, occupancy, flush counter and the post-reset run flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v    <= '0;
      r_occ  <= '0;
      r_fcnt <= 16'h0000;
      r_run  <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        r_d[i] <= '0;
      end
    end else begin
      r_run <= 1'b1;
      r_v   <= w_v_nxt;
      r_occ <= popcount(w_v_nxt);
      if (w_load[0]) begin
        r_d[0] <= in_data;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (w_load[i]) begin
          r_d[i] <= r_d[i-1];
        end
      end
      if (w_kill_any && (r_fcnt != 16'hFFFF)) begin
        r_fcnt <= r_fcnt + 16'd1;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_v[STAGES-1];
  assign out_data  = r_d[STAGES-1];
  assign occupancy = r_occ;
  assign flush_cnt = r_fcnt;

endmodule

// File: doc/pipe_ctrl_chain.md
PIPE_CTRL_CHAIN -- requirements
Module: pipe_ctrl_chain

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clock port clk, reset port rst.
REQ-002 Parameter DATA_W, default 32: payload width in bits.
REQ-003 Parameter STAGES, default 5: number of register stages; legal range 2..16.
REQ-004 Parameter FLUSH_DEPTH, default 2: number of youngest stages cleared by flush; legal range 1..STAGES.
REQ-005 clk  in  1: rising-edge clock.
REQ-006 rst  in  1: asynchronous reset, active low.
REQ-007 in_valid  in  1: upstream offers in_data.
REQ-008 in_data  in  DATA_W: upstream payload.
REQ-009 in_ready  out  1: stage 0 accepts this cycle.
REQ-010 freeze  in  1: global stall; all stages hold.
REQ-011 flush  in  1: kills stages 0..FLUSH_DEPTH-1 (branch-taken style).
REQ-012 out_valid  out  1: stage STAGES-1 holds a valid entry.
REQ-013 out_data  out  DATA_W: payload of stage STAGES-1.
REQ-014 out_ready  in  1: downstream accepts.
REQ-015 occupancy  out  clog2(STAGES+1): count of valid stages.
REQ-016 flush_cnt  out  16: count of flush cycles that killed at least one valid entry.

Function
REQ-017 Each stage i (0 = youngest, STAGES-1 = output) SHALL hold a valid bit v[i] and a DATA_W data register d[i].
REQ-018 Output stage drains when out_valid && out_ready && !freeze.
REQ-019 Stage i < STAGES-1 SHALL forward into stage i+1 when v[i] && !freeze && (!v[i+1] || stage i+1 drains/forwards the same cycle): bubbles collapse.
REQ-020 in_ready SHALL be combinational: !freeze && !flush && (!v[0] || stage 0 forwards this cycle).
REQ-021 A transfer SHALL occur at stage 0 iff in_valid && in_ready; d[0] <= in_data, v[0] <= 1.
REQ-022 A stage with no incoming transfer SHALL clear v[i] when its entry leaves; d[i] is unchanged.
REQ-023 Unstalled latency: a word accepted at edge t SHALL present out_valid=1 with that word after edge t+STAGES-1, i.e. visible STAGES cycles after the accept cycle.
REQ-024 Order SHALL be preserved; no entry is duplicated or lost except by flush.
REQ-025 Flush: at the edge, v[0..FLUSH_DEPTH-1] <= 0; an entry leaving stage FLUSH_DEPTH-1 that cycle SHALL NOT be written into stage FLUSH_DEPTH.
REQ-026 Stages >= FLUSH_DEPTH SHALL advance/drain normally during flush (subject to freeze).
REQ-027 flush && freeze: flushed stages cleared, all other stages hold.
REQ-028 FLUSH_DEPTH = STAGES: the flush also kills the output entry; out_valid = 0 next cycle, and no drain counts that cycle.
REQ-029 occupancy SHALL equal popcount(v), registered, consistent with v at all times.
REQ-030 flush_cnt SHALL increment by 1 on each edge with flush=1 and any v[0..FLUSH_DEPTH-1]=1, and saturate at 0xFFFF.
REQ-031 out_data SHALL equal d[STAGES-1] regardless of out_valid.

Reset
REQ-032 rst=0 SHALL asynchronously force all v to 0, all d to 0, occupancy 0, flush_cnt 0; out_valid=0, out_data=0 immediately.
REQ-033 While rst=0, in_ready SHALL be 0; release is synchronous to the next clk edge after rst=1.
REQ-034 Reset asserted mid-stream discards all entries; no partial transfer survives.

Verification (STAGES=5, DATA_W=32, FLUSH_DEPTH=2)
REQ-035 Stream 0x1..0xA back-to-back, out_ready=1 -> first out_data=0x1 five cycles after its accept, 0x1..0xA in order, occupancy settles at 5.
REQ-036 Fill with 0x10..0x14, out_ready=0 -> occupancy=5, in_ready=0; then out_ready=1 for one cycle -> 0x10 drains, in_ready=1 that cycle.
REQ-037 Full pipe 0x20..0x24, assert flush one cycle, out_ready=1 -> 0x23/0x24 killed, 0x20..0x22 delivered, flush_cnt=1.
REQ-038 Stream with freeze=1 for 3 cycles -> no stage changes, in_ready=0, out_valid held; resume yields no loss or duplicate.
REQ-039 flush && freeze on full pipe -> occupancy 5 -> 3, remaining entries unchanged.
REQ-040 Assert rst=0 mid-stream -> out_valid=0, occupancy=0, flush_cnt=0 without clk edge; after release, a new 0xAA emerges alone.
